// File: rtl/ysyx_24080014_wbu_pkg.sv
// Shared encodings for the write-back unit, also used by the decoder.
//   wb_sel_e   : destination data source select
//   load_fmt_e : load width / extension format
//   wbu_state_e: write-back FSM states
package ysyx_24080014_wbu_pkg;

  typedef enum logic [2:0] {
    WB_ALU    = 3'b000,
    WB_LOAD   = 3'b001,
    WB_PC_ADD = 3'b010,
    WB_CSR    = 3'b011,
    WB_IMM    = 3'b100
  } wb_sel_e;

  typedef enum logic [2:0] {
    LF_LB  = 3'b000,
    LF_LH  = 3'b001,
    LF_LW  = 3'b010,
    LF_LBU = 3'b100,
    LF_LHU = 3'b101
  } load_fmt_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_WAIT_MEM = 2'b01,
    S_WRITE    = 2'b10
  } wbu_state_e;

  localparam int TO_CNT_W = 8;

endpackage

// File: rtl/ysyx_24080014_wbu_if.sv
// Bundle of the write-back unit's upstream handshake, memory response and
// register-file write signals.
//   slave : the write-back unit side
//   master: the surrounding pipeline / memory / register-file side
interface ysyx_24080014_wbu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      wb_sel;
  logic [2:0]      load_fmt;
  logic [4:0]      rd_addr;
  logic            rd_wen;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] csr_rdata;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            rf_wen;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            commit;
  logic            load_err;

  modport slave (
    input  in_valid, wb_sel, load_fmt, rd_addr, rd_wen, alu_result, pc, imm,
           csr_rdata, mem_rvalid, mem_rdata,
    output in_ready, rf_wen, rf_waddr, rf_wdata, commit, load_err
  );

  modport master (
    output in_valid, wb_sel, load_fmt, rd_addr, rd_wen, alu_result, pc, imm,
           csr_rdata, mem_rvalid, mem_rdata,
    input  in_ready, rf_wen, rf_waddr, rf_wdata, commit, load_err
  );
endinterface

// File: rtl/ysyx_24080014_wbu_load_align.sv
// Load data aligner: picks the addressed byte/half out of a word-aligned
// memory read and sign- or zero-extends it.
//   mem_rdata_i : word-aligned load data
//   off_i       : byte offset (address[1:0])
//   load_fmt_i  : load format; unknown codes behave as LW
//   data_o      : aligned, extended result
module ysyx_24080014_load_align
  import ysyx_24080014_wbu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      load_fmt_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = mem_rdata_i[8*off_i +: 8];
    // Half loads use only off[1]; a misaligned off[0] is ignored.
    half_v = off_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (load_fmt_i)
      LF_LB:   data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      LF_LH:   data_o = {{(XLEN-16){half_v[15]}}, half_v};
      LF_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_v};
      LF_LHU:  data_o = {{(XLEN-16){1'b0}}, half_v};
      default: data_o = mem_rdata_i;
    endcase
  end

endmodule

// File: rtl/ysyx_24080014_wbu.sv
// Write-back unit: accepts one retiring instruction per handshake, selects
// its destination data (ALU / load / pc+4 / CSR / imm), waits for the load
// response where needed, then issues a one-cycle register-file write and
// commit pulse. A load with no response within MEM_TIMEOUT cycles aborts
// with a load_err pulse instead.
//   clk, rst : clock, asynchronous active-high reset
//   wb       : slave side of the write-back bundle (handshake, memory
//              response, register-file write, commit, load_err)
module ysyx_24080014_wbu
  import ysyx_24080014_wbu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  ysyx_24080014_wbu_if.slave wb
);

  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(MEM_TIMEOUT - 1);

  wbu_state_e          state_q, state_d;
  logic [TO_CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]      fmt_q;
  logic [1:0]      off_q;
  logic [4:0]      rd_q;
  logic            wen_q;
  logic            err_q, err_d;
  logic [4:0]      waddr_q;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic            accept;
  logic [XLEN-1:0] sel_res;
  logic [XLEN-1:0] ld_data;

  assign accept = (state_q == S_IDLE) && wb.in_valid;

  ysyx_24080014_load_align #(.XLEN(XLEN)) u_align (
    .mem_rdata_i (wb.mem_rdata),
    .off_i       (off_q),
    .load_fmt_i  (fmt_q),
    .data_o      (ld_data)
  );

  // Non-load result, captured in the accept cycle.
  always_comb begin
    case (wb.wb_sel)
      WB_ALU:    sel_res = wb.alu_result;
      WB_PC_ADD: sel_res = wb.pc + XLEN'(4);
      WB_CSR:    sel_res = wb.csr_rdata;
      WB_IMM:    sel_res = wb.imm;
      default:   sel_res = '0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wb.in_valid) begin
          state_d = (wb.wb_sel == WB_LOAD) ? S_WAIT_MEM : S_WRITE;
          cnt_d   = '0;
        end
      end
      S_WAIT_MEM: begin
        if (wb.mem_rvalid) begin
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // Counter is about to reach MEM_TIMEOUT: give up on this load.
          if (cnt_q == TO_LAST) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs, decoded from the registered state
  always_comb begin
    wb.in_ready = (state_q == S_IDLE);
    wb.commit   = (state_q == S_WRITE);
    wb.rf_wen   = (state_q == S_WRITE) && wen_q && (waddr_q != 5'd0);
    wb.load_err = err_q;
    wb.rf_waddr = waddr_q;
    wb.rf_wdata = wdata_q;
  end

  // Write data source depends on which state is entering WRITE.
  assign wdata_d = (state_q == S_IDLE) ? sel_res : ld_data;

  // Captured instruction fields; waddr/wdata only move when a write is
  // about to be presented, so they hold across idle and timeout cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fmt_q   <= '0;
      off_q   <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      err_q <= err_d;
      if (accept) begin
        fmt_q <= wb.load_fmt;
        off_q <= wb.alu_result[1:0];
        rd_q  <= wb.rd_addr;
        wen_q <= wb.rd_wen;
      end
      if (state_d == S_WRITE) begin
        waddr_q <= (state_q == S_IDLE) ? wb.rd_addr : rd_q;
        wdata_q <= wdata_d;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24080014_wbu.sv
// Scoreboard bench for the write-back unit: the driver pushes the expected
// commit / load_err event (data and cycle) computed by a reference model; a
// monitor pops and compares whenever the unit reports an event.
module tb_ysyx_24080014_wbu;

  localparam int MEM_TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_24080014_wbu_if #(.XLEN(32)) bus ();

  ysyx_24080014_wbu #(.XLEN(32), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  typedef struct {
    bit          err;
    bit          wen;
    logic [4:0]  a;
    logic [31:0] d;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference model: result from the selection / load-format rules.
  function automatic logic [31:0] ref_res(input logic [2:0] sel, input logic [2:0] fmt,
                                          input logic [31:0] alu, input logic [31:0] pcv,
                                          input logic [31:0] immv, input logic [31:0] csrv,
                                          input logic [31:0] rdata);
    logic [31:0] b, h;
    int unsigned off;
    off = alu % 4;
    b = (rdata >> (8 * off)) % 256;
    h = (rdata >> ((off >= 2) ? 16 : 0)) % 65536;
    case (sel)
      3'd0: return alu;
      3'd2: return pcv + 32'd4;
      3'd3: return csrv;
      3'd4: return immv;
      3'd1: begin
        case (fmt)
          3'd0: return (b >= 128) ? b - 32'd256 : b;
          3'd1: return (h >= 32768) ? h - 32'd65536 : h;
          3'd4: return b;
          3'd5: return h;
          default: return rdata;
        endcase
      end
      default: return 32'd0;
    endcase
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rf_wen && !bus.commit) begin
        n_chk++;
        $display("FAIL wen_without_commit: cyc %0d", cyc);
      end
      if (bus.commit || bus.load_err) begin
        exp_t e;
        n_chk++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_event: cyc %0d commit %b load_err %b wen %b", cyc,
                   bus.commit, bus.load_err, bus.rf_wen);
        end else begin
          e = q.pop_front();
          if (e.err ? (bus.load_err && !bus.commit && !bus.rf_wen && cyc == e.cyc)
                    : (bus.commit && !bus.load_err && bus.rf_wen == e.wen &&
                       bus.rf_waddr == e.a && bus.rf_wdata == e.d && cyc == e.cyc))
            n_pass++;
          else
            $display("FAIL event: got err=%b commit=%b wen=%b a=%0d d=%h cyc=%0d, expected err=%b wen=%b a=%0d d=%h cyc=%0d",
                     bus.load_err, bus.commit, bus.rf_wen, bus.rf_waddr, bus.rf_wdata, cyc,
                     e.err, e.wen, e.a, e.d, e.cyc);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
  endtask

  // Called at a negedge. dly>=1: rvalid sampled dly edges after accept;
  // dly=-1: no response (timeout); dly=-2: no response, caller resets.
  task automatic issue(input logic [2:0] sel, input logic [2:0] fmt, input logic [4:0] rd,
                       input logic wen, input logic [31:0] alu, input logic [31:0] pcv,
                       input logic [31:0] immv, input logic [31:0] csrv,
                       input logic [31:0] rdata, input int dly, input bit hold);
    exp_t e;
    wait_ready();
    bus.in_valid = 1'b1;
    bus.wb_sel = sel; bus.load_fmt = fmt; bus.rd_addr = rd; bus.rd_wen = wen;
    bus.alu_result = alu; bus.pc = pcv; bus.imm = immv; bus.csr_rdata = csrv;
    e.err = 0; e.wen = wen && (rd != 0); e.a = rd;
    e.d = ref_res(sel, fmt, alu, pcv, immv, csrv, rdata);
    if (sel != 3'd1) begin
      e.cyc = cyc + 1;
      q.push_back(e);
      @(negedge clk);
      chk("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
      if (!hold) bus.in_valid = 1'b0;
    end else begin
      int acc = cyc + 1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (dly == -1) begin
        e.err = 1; e.cyc = acc + MEM_TIMEOUT;
        q.push_back(e);
      end else if (dly >= 1) begin
        repeat (dly - 1) @(negedge clk);
        e.cyc = cyc + 1;
        q.push_back(e);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = rdata;
        @(negedge clk);
        bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
      end
    end
  endtask

  initial begin
    bus.in_valid = 0; bus.wb_sel = 0; bus.load_fmt = 0; bus.rd_addr = 0; bus.rd_wen = 0;
    bus.alu_result = 0; bus.pc = 0; bus.imm = 0; bus.csr_rdata = 0;
    bus.mem_rvalid = 0; bus.mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {bus.rf_wen, bus.commit, bus.load_err, bus.rf_waddr, 24'd0},
        32'd0);
    chk("reset_wdata", bus.rf_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // ALU path, PC wrap, x0
    issue(3'd0, 3'd0, 5'd5, 1, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
    issue(3'd2, 3'd0, 5'd1, 1, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 0, 0);
    issue(3'd2, 3'd0, 5'd0, 1, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 0, 0);
    issue(3'd3, 3'd0, 5'd7, 1, 32'h0, 32'h0, 32'h0, 32'hCAFE_F00D, 32'h0, 0, 0);
    issue(3'd4, 3'd0, 5'd8, 1, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 0);
    issue(3'd6, 3'd0, 5'd9, 1, 32'h55, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);

    // Load extension cases
    issue(3'd1, 3'd0, 5'd10, 1, 32'h0000_1001, 0, 0, 0, 32'h80FF_7F01, 1, 0);
    issue(3'd1, 3'd0, 5'd11, 1, 32'h0000_1002, 0, 0, 0, 32'h80FF_7F01, 2, 0);
    issue(3'd1, 3'd5, 5'd12, 1, 32'h0000_1002, 0, 0, 0, 32'h80FF_7F01, 1, 0);
    issue(3'd1, 3'd1, 5'd13, 1, 32'h0000_1003, 0, 0, 0, 32'h80FF_7F01, 1, 0);
    issue(3'd1, 3'd2, 5'd14, 1, 32'h0000_1000, 0, 0, 0, 32'h80FF_7F01, 3, 0);

    // Timeout, then a stray rvalid in IDLE
    issue(3'd1, 3'd2, 5'd15, 1, 32'h0000_2000, 0, 0, 0, 32'h0, -1, 0);
    wait_ready();
    chk("in_ready_after_timeout", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.mem_rvalid = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("in_ready_after_stray", {31'd0, bus.in_ready}, 32'd1);

    // Reset during WAIT_MEM discards the load
    issue(3'd1, 3'd2, 5'd16, 1, 32'h0000_3000, 0, 0, 0, 32'h0, -2, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_outs", {bus.rf_wen, bus.commit, bus.load_err, bus.rf_waddr, 24'd0}, 32'd0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_in_ready_after", {31'd0, bus.in_ready}, 32'd1);

    // Back-to-back with in_valid held high
    issue(3'd0, 3'd0, 5'd20, 1, 32'hA, 0, 0, 0, 0, 0, 1);
    issue(3'd0, 3'd0, 5'd21, 1, 32'hB, 0, 0, 0, 0, 0, 1);
    issue(3'd0, 3'd0, 5'd22, 1, 32'hC, 0, 0, 0, 0, 0, 0);

    // Randomized mix
    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 5'($urandom),
            1'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom,
            int'($urandom_range(1, 4)), 1'($urandom));
    end
    bus.in_valid = 1'b0;

    begin
      int n = 0;
      while (q.size() != 0 && n < 1000) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_24080014_wbu.md
Name: ysyx_24080014_wbu

Overview:
- Write-back unit at the result end of the execute datapath; the counterpart of the operand-select stage that feeds the ALU.
- Accepts one retiring instruction per handshake and selects its destination data from: ALU result, load data, pc+4, CSR read data, or immediate.
- For loads, waits for the memory response, then aligns and sign- or zero-extends it.
- Issues a single-cycle register-file write and a commit pulse.

Parameters:
- XLEN, 32, datapath width.
- MEM_TIMEOUT, 255, max cycles waiting in WAIT_MEM before aborting; 8-bit counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream holds a retiring instruction.
- in_ready  output  1  unit can accept; high only in IDLE.
- wb_sel  input  3  destination source select: 000 ALU, 001 LOAD, 010 PC_ADD, 011 CSR_DATA, 100 IMM; other codes write 0.
- load_fmt  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes are treated as LW.
- rd_addr  input  5  destination register.
- rd_wen  input  1  instruction writes rd.
- alu_result  input  XLEN  ALU output; also the load address.
- pc  input  XLEN  instruction pc.
- imm  input  XLEN  decoded immediate.
- csr_rdata  input  XLEN  old CSR value.
- mem_rvalid  input  1  load data valid.
- mem_rdata  input  XLEN  word-aligned load data.
- rf_wen  output  1  register-file write strobe.
- rf_waddr  output  5  write address.
- rf_wdata  output  XLEN  write data.
- commit  output  1  one-cycle pulse per retired instruction.
- load_err  output  1  one-cycle pulse on memory timeout.

Behaviour:
- Reset: state=IDLE, timeout counter=0, all captured registers=0. Outputs: rf_wen=0, rf_waddr=0, rf_wdata=0, commit=0, load_err=0, in_ready=1 after reset deasserts.
- States are IDLE, WAIT_MEM and WRITE.
- IDLE, in_valid=1 (accept):
  - Capture wb_sel, load_fmt, rd_addr, rd_wen, and alu_result[1:0] as the byte offset.
  - wb_sel=LOAD → WAIT_MEM, counter cleared.
  - Otherwise → WRITE, with the result captured this cycle: ALU=alu_result, PC_ADD=pc+4 (mod 2^32, wraps), CSR_DATA=csr_rdata, IMM=imm, others=0.
- WAIT_MEM:
  - mem_rvalid=1 → capture the aligned, extended data; → WRITE.
  - Byte loads select mem_rdata[8*off+7:8*off].
  - Half loads select mem_rdata[16*off[1]+15:16*off[1]]; off[0] is ignored.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the word unchanged.
  - No rvalid: counter increments. When the counter reaches MEM_TIMEOUT → IDLE, load_err pulses for 1 cycle, no write, no commit.
- WRITE (exactly one cycle):
  - rf_wen = captured rd_wen && rd_addr!=0; rf_waddr and rf_wdata driven from the captured values.
  - commit=1, including when no write occurs (rd_wen=0 or x0).
  - → IDLE.
- Outputs are registered from state; rf_wen, commit and load_err are 0 outside their defined cycles. rf_wdata and rf_waddr hold their last values.
- Latency:
  - Non-load: accept at edge N → rf_wen/commit high during cycle N+1; next accept possible at edge N+2.
  - Load: rvalid sampled at edge M → write during cycle M+1.
- Throughput: at most one instruction every 2 cycles for non-loads.
- mem_rvalid outside WAIT_MEM is ignored; it causes no state change.
- in_valid while not in IDLE is not accepted; the upstream stage must hold its inputs stable.
- Reset asserted mid-operation (WAIT_MEM or WRITE) discards the pending instruction. There is no write and no commit; outputs return to reset values immediately (async).

Decomposition:
- Shared package/header holds the wb_sel codes, the load_fmt codes and the state encodings, shared with the decoder.
- One sub-module: ysyx_24080014_load_align (combinational; inputs mem_rdata, offset, load_fmt; output extended data).
- Result select and the FSM live in the top.

Test Plan:
- ALU path: wb_sel=000, alu_result=0x0000_1234, rd=5, rd_wen=1 → next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x0000_1234, commit=1; in_ready low for exactly 1 cycle.
- PC_ADD wrap and x0: pc=0xFFFF_FFFC, wb_sel=010, rd=1 → rf_wdata=0x0000_0000. The same instruction with rd=0 → rf_wen=0 and commit=1.
- Load extend: mem_rdata=0x80FF_7F01.
  - LB, off=1 → 0x0000_007F.
  - LB, off=2 → 0xFFFF_FFFF.
  - LHU, off=2 → 0x0000_80FF.
  - LH, off=2 → 0xFFFF_80FF.
  - LW → 0x80FF_7F01.
  - rvalid arriving 3 cycles after accept → write in the 4th cycle.
- Timeout: LOAD accepted, no mem_rvalid for MEM_TIMEOUT cycles → load_err pulse, no rf_wen, no commit, in_ready returns to 1. A later stray rvalid is ignored.
- Reset mid-load: assert rst while in WAIT_MEM, then send rvalid after release → no write and no commit; in_ready=1.
- Back-to-back: in_valid held high with 3 ALU instructions → commits in cycles 1, 3 and 5 after the first accept, with data in order.
